sha256_msg_padder: RTL and testbench

- Upstream feeder for the SHA-256 core.
- Accepts an arbitrary-length byte message as a 32-bit word stream with valid/ready handshake.
- Applies FIPS 180-4 padding: 0x80 terminator, zero fill, 64-bit big-endian bit length.
- Emits each 512-bit block to the core as 16 contiguous word beats, then waits for the core's completion pulse before emitting the next block.

---
 rtl/sha256_msg_padder.sv | 281 ++++++++++++++++++++++++++++
 tb/tb_sha256_msg_padder.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha256_msg_padder.sv
// SHA-256 message padder.
// Collects a byte message arriving as LSB-first 32-bit words into a
// 512-bit block buffer. It appends the 0x80 terminator, zero fill and the
// 64-bit big-endian bit length. Each block is streamed to the hash core as
// 16 back-to-back beats, and the padder then waits for the core's done pulse.
module sha256_msg_padder #(
  parameter int LEN_W = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        s_valid,
  output logic        s_ready,
  input  logic [31:0] s_data,
  input  logic        s_last,
  input  logic [2:0]  s_nbytes,
  output logic        blk_valid_o,
  output logic [31:0] blk_data_o,
  output logic        blk_first_o,
  input  logic        core_busy_i,
  input  logic        core_done_i,
  output logic        msg_done_o,
  output logic        busy_o
);

  typedef enum logic [2:0] {
    ST_FILL = 3'd0,
    ST_PAD  = 3'd1,
    ST_ARM  = 3'd2,
    ST_SEND = 3'd3,
    ST_WAIT = 3'd4
  } state_t;

  // Reverse byte order: the length field is big-endian, but the stream is LSB-first.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

  state_t             state_r;
  state_t             state_nxt_s;
  logic [31:0]        buf_r [16];
  logic [3:0]         widx_r;
  logic [3:0]         bidx_r;
  logic [LEN_W-1:0]   cnt_r;
  logic               first_r;
  logic               need_extra_r;
  logic               last_blk_r;
  logic               term_placed_r;
  logic [3:0]         last_widx_r;
  logic [2:0]         last_nb_r;

  logic               s_ready_r;
  logic               blk_valid_r;
  logic [31:0]        blk_data_r;
  logic               blk_first_r;
  logic               msg_done_r;
  logic               busy_r;

  logic               fire_s;
  logic [2:0]         nb_eff_s;
  logic [6:0]         p_s;
  logic [6:0]         pos_s;
  logic [31:0]        word_s;
  logic [63:0]        len64_s;
  logic [31:0]        len_hi_s;
  logic [31:0]        len_lo_s;
  logic [31:0]        pad_blk_s [16];
  logic [31:0]        extra_blk_s [16];

  // s_ready_r mirrors "state is FILL". It is forced low while reset is asserted.
  assign s_ready     = s_ready_r & ~rst;
  assign blk_valid_o = blk_valid_r;
  assign blk_data_o  = blk_data_r;
  assign blk_first_o = blk_first_r;
  assign msg_done_o  = msg_done_r;
  assign busy_o      = busy_r;

  // Input handshake, effective byte count, terminator position and length words.
  always_comb begin
    fire_s   = s_valid & s_ready_r;
    nb_eff_s = (s_last && (s_nbytes <= 3'd4)) ? s_nbytes : 3'd4;
    p_s      = {1'b0, last_widx_r, 2'b00} +
               ((last_nb_r == 3'd4) ? 7'd4 : {4'b0000, last_nb_r});
    len64_s  = 64'({cnt_r, 3'b000});
    len_hi_s = bswap32(len64_s[63:32]);
    len_lo_s = bswap32(len64_s[31:0]);
  end

  // Padded version of the current buffer: 0x80 at p, zeros after, length if it fits.
  always_comb begin
    pos_s  = 7'd0;
    word_s = 32'h0000_0000;
    for (int w = 0; w < 16; w++) begin
      word_s = buf_r[w];
      for (int k = 0; k < 4; k++) begin
        pos_s = 7'(w * 4 + k);
        if (pos_s == p_s) begin
          word_s[8*k +: 8] = 8'h80;
        end else if (pos_s > p_s) begin
          word_s[8*k +: 8] = 8'h00;
        end else begin
          word_s[8*k +: 8] = buf_r[w][8*k +: 8];
        end
      end
      if ((p_s <= 7'd55) && (w == 14)) begin
        pad_blk_s[w] = len_hi_s;
      end else if ((p_s <= 7'd55) && (w == 15)) begin
        pad_blk_s[w] = len_lo_s;
      end else begin
        pad_blk_s[w] = word_s;
      end
    end
  end

  // Extra trailing block: terminator only if it did not fit before, plus length.
  always_comb begin
    for (int w = 0; w < 16; w++) begin
      extra_blk_s[w] = 32'h0000_0000;
    end
    extra_blk_s[0]  = term_placed_r ? 32'h0000_0000 : 32'h0000_0080;
    extra_blk_s[14] = len_hi_s;
    extra_blk_s[15] = len_lo_s;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_FILL;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_FILL: begin
        if (fire_s) begin
          if (s_last) begin
            state_nxt_s = ST_PAD;
          end else if (widx_r == 4'd15) begin
            state_nxt_s = ST_ARM;
          end else begin
            state_nxt_s = ST_FILL;
          end
        end else begin
          state_nxt_s = ST_FILL;
        end
      end
      ST_PAD: begin
        state_nxt_s = ST_ARM;
      end
      ST_ARM: begin
        // A block only starts streaming once the core is idle.
        if (!core_busy_i) begin
          state_nxt_s = ST_SEND;
        end else begin
          state_nxt_s = ST_ARM;
        end
      end
      ST_SEND: begin
        if (bidx_r == 4'd15) begin
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_SEND;
        end
      end
      ST_WAIT: begin
        if (core_done_i) begin
          if (last_blk_r) begin
            state_nxt_s = ST_FILL;
          end else if (need_extra_r) begin
            state_nxt_s = ST_ARM;
          end else begin
            state_nxt_s = ST_FILL;
          end
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      default: begin
        state_nxt_s = ST_FILL;
      end
    endcase
  end

  // Block buffer, counters and per-message flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 16; i++) begin
        buf_r[i] <= 32'h0000_0000;
      end
      widx_r        <= 4'd0;
      bidx_r        <= 4'd0;
      cnt_r         <= '0;
      first_r       <= 1'b1;
      need_extra_r  <= 1'b0;
      last_blk_r    <= 1'b0;
      term_placed_r <= 1'b0;
      last_widx_r   <= 4'd0;
      last_nb_r     <= 3'd0;
    end else begin
      case (state_r)
        ST_FILL: begin
          if (fire_s) begin
            buf_r[widx_r] <= s_data;
            cnt_r         <= cnt_r + LEN_W'(nb_eff_s);
            widx_r        <= widx_r + 4'd1;
            if (s_last) begin
              last_widx_r <= widx_r;
              last_nb_r   <= nb_eff_s;
            end else if (widx_r == 4'd15) begin
              last_blk_r  <= 1'b0;
            end
          end
        end
        ST_PAD: begin
          for (int i = 0; i < 16; i++) begin
            buf_r[i] <= pad_blk_s[i];
          end
          last_blk_r    <= (p_s <= 7'd55);
          need_extra_r  <= (p_s >= 7'd56);
          // A full last block (p = 64) defers the terminator to the extra block.
          term_placed_r <= (p_s != 7'd64);
        end
        ST_ARM: begin
          bidx_r <= 4'd0;
        end
        ST_SEND: begin
          bidx_r <= bidx_r + 4'd1;
          if (bidx_r == 4'd15) begin
            first_r <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (core_done_i) begin
            if (last_blk_r) begin
              cnt_r         <= '0;
              widx_r        <= 4'd0;
              first_r       <= 1'b1;
              last_blk_r    <= 1'b0;
              need_extra_r  <= 1'b0;
              term_placed_r <= 1'b0;
            end else if (need_extra_r) begin
              for (int i = 0; i < 16; i++) begin
                buf_r[i] <= extra_blk_s[i];
              end
              last_blk_r   <= 1'b1;
              need_extra_r <= 1'b0;
            end else begin
              widx_r <= 4'd0;
            end
          end
        end
        default: begin
          widx_r <= 4'd0;
        end
      endcase
    end
  end

  // Registered outputs toward the source, the core and the status pins.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_ready_r   <= 1'b1;
      blk_valid_r <= 1'b0;
      blk_data_r  <= 32'h0000_0000;
      blk_first_r <= 1'b0;
      msg_done_r  <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      s_ready_r   <= (state_nxt_s == ST_FILL);
      blk_valid_r <= (state_r == ST_SEND);
      blk_data_r  <= (state_r == ST_SEND) ? buf_r[bidx_r] : 32'h0000_0000;
      blk_first_r <= (state_r == ST_SEND) & first_r;
      msg_done_r  <= (state_r == ST_WAIT) & core_done_i & last_blk_r;
      busy_r      <= (state_r != ST_FILL) | (widx_r != 4'd0) | (cnt_r != '0);
    end
  end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Directed bench for sha256_msg_padder: a core stand-in pulses core_done_i.
module tb_sha256_msg_padder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_data = 32'h0;
  logic        s_last = 1'b0;
  logic [2:0]  s_nbytes = 3'd0;
  logic        blk_valid_o;
  logic [31:0] blk_data_o;
  logic        blk_first_o;
  logic        core_busy_i = 1'b0;
  logic        core_done_i = 1'b0;
  logic        msg_done_o;
  logic        busy_o;

  int          total_cnt = 0;
  int          pass_cnt = 0;
  logic [31:0] cap_w [16];
  logic [31:0] exp_w [16];
  logic [15:0] cap_vv;
  logic [15:0] cap_fv;
  logic        cap_after;

  sha256_msg_padder #(.LEN_W(32)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .s_nbytes(s_nbytes),
    .blk_valid_o(blk_valid_o), .blk_data_o(blk_data_o), .blk_first_o(blk_first_o),
    .core_busy_i(core_busy_i), .core_done_i(core_done_i),
    .msg_done_o(msg_done_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [31:0] mkw(input int b);
    return {8'(b + 3), 8'(b + 2), 8'(b + 1), 8'(b)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic [2:0] nb, input logic last);
    int n;
    n = 0;
    s_valid = 1'b1; s_data = d; s_nbytes = nb; s_last = last;
    while (s_ready !== 1'b1 && n < 300) begin tick(); n++; end
    total_cnt++;
    if (s_ready !== 1'b1) $display("FAIL send_word: s_ready=%b, expected 1 within 300 cycles", s_ready);
    else pass_cnt++;
    tick();
    s_valid = 1'b0; s_last = 1'b0;
  endtask

  task automatic send_msg(input int nbytes);
    int nw;
    nw = (nbytes == 0) ? 1 : (nbytes + 3) / 4;
    for (int w = 0; w < nw; w++)
      send_word(mkw(4 * w), (w == nw - 1) ? 3'(nbytes - 4 * w) : 3'd4, w == nw - 1);
  endtask

  task automatic capture_block();
    int n;
    n = 0;
    for (int i = 0; i < 16; i++) cap_w[i] = 32'hxxxx_xxxx;
    cap_vv = 16'h0000; cap_fv = 16'h0000; cap_after = 1'b1;
    while (blk_valid_o !== 1'b1 && n < 80) begin tick(); n++; end
    total_cnt++;
    if (blk_valid_o !== 1'b1) begin
      $display("FAIL block_start: blk_valid_o=%b, expected 1 within 80 cycles", blk_valid_o);
    end else begin
      pass_cnt++;
      for (int i = 0; i < 16; i++) begin
        if (i != 0) tick();
        cap_vv[i] = blk_valid_o; cap_fv[i] = blk_first_o; cap_w[i] = blk_data_o;
      end
      tick();
      cap_after = blk_valid_o;
    end
  endtask

  task automatic pulse_done();
    core_done_i = 1'b1;
    tick();
    core_done_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) tick();
    total_cnt++;
    if ({s_ready, blk_valid_o, blk_first_o, msg_done_o, busy_o} !== 5'b00000 || blk_data_o !== 32'h0)
      $display("FAIL reset_outputs: got rdy=%b v=%b f=%b md=%b busy=%b data=%h, expected all 0",
               s_ready, blk_valid_o, blk_first_o, msg_done_o, busy_o, blk_data_o);
    else pass_cnt++;
    rst = 1'b0;
    tick();
    total_cnt++;
    if (s_ready !== 1'b1 || busy_o !== 1'b0)
      $display("FAIL reset_release: s_ready=%b busy=%b, expected 1 0", s_ready, busy_o);
    else pass_cnt++;
  endtask

  task automatic test_abc();
    send_word(32'h0063_6261, 3'd3, 1'b1);
    capture_block();
    for (int i = 0; i < 16; i++) exp_w[i] = 32'h0;
    exp_w[0] = 32'h8063_6261; exp_w[15] = 32'h1800_0000;
    for (int i = 0; i < 16; i++) begin
      total_cnt++;
      if (cap_w[i] !== exp_w[i]) $display("FAIL abc_word%0d: got %h expected %h", i, cap_w[i], exp_w[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (cap_vv !== 16'hFFFF || cap_after !== 1'b0 || cap_fv !== 16'hFFFF)
      $display("FAIL abc_beats: valid=%h after=%b first=%h expected FFFF 0 FFFF", cap_vv, cap_after, cap_fv);
    else pass_cnt++;
    total_cnt++;
    if (busy_o !== 1'b1 || s_ready !== 1'b0)
      $display("FAIL abc_wait: busy=%b s_ready=%b expected 1 0", busy_o, s_ready);
    else pass_cnt++;
    pulse_done();
    total_cnt++;
    if (msg_done_o !== 1'b1) $display("FAIL abc_msg_done: got %b expected 1", msg_done_o);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (msg_done_o !== 1'b0 || busy_o !== 1'b0)
      $display("FAIL abc_after: msg_done=%b busy=%b expected 0 0", msg_done_o, busy_o);
    else pass_cnt++;
  endtask

  task automatic test_empty();
    send_msg(0);
    capture_block();
    for (int i = 0; i < 16; i++) exp_w[i] = 32'h0;
    exp_w[0] = 32'h0000_0080;
    for (int i = 0; i < 16; i++) begin
      total_cnt++;
      if (cap_w[i] !== exp_w[i]) $display("FAIL empty_word%0d: got %h expected %h", i, cap_w[i], exp_w[i]);
      else pass_cnt++;
    end
    pulse_done();
    total_cnt++;
    if (msg_done_o !== 1'b1 || cap_fv !== 16'hFFFF)
      $display("FAIL empty_done: msg_done=%b first=%h expected 1 FFFF", msg_done_o, cap_fv);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_len55();
    send_msg(55);
    capture_block();
    for (int i = 0; i < 13; i++) exp_w[i] = mkw(4 * i);
    exp_w[13] = 32'h8036_3534; exp_w[14] = 32'h0; exp_w[15] = 32'hB801_0000;
    for (int i = 0; i < 16; i++) begin
      total_cnt++;
      if (cap_w[i] !== exp_w[i]) $display("FAIL len55_word%0d: got %h expected %h", i, cap_w[i], exp_w[i]);
      else pass_cnt++;
    end
    pulse_done();
    total_cnt++;
    if (msg_done_o !== 1'b1) $display("FAIL len55_done: msg_done=%b expected 1", msg_done_o);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_len56();
    send_msg(56);
    capture_block();
    for (int i = 0; i < 14; i++) exp_w[i] = mkw(4 * i);
    exp_w[14] = 32'h0000_0080; exp_w[15] = 32'h0;
    for (int i = 0; i < 16; i++) begin
      total_cnt++;
      if (cap_w[i] !== exp_w[i]) $display("FAIL len56_b1_word%0d: got %h expected %h", i, cap_w[i], exp_w[i]);
      else pass_cnt++;
    end
    pulse_done();
    total_cnt++;
    if (msg_done_o !== 1'b0 || cap_fv !== 16'hFFFF)
      $display("FAIL len56_b1_flags: msg_done=%b first=%h expected 0 FFFF", msg_done_o, cap_fv);
    else pass_cnt++;
    capture_block();
    for (int i = 0; i < 16; i++) exp_w[i] = 32'h0;
    exp_w[15] = 32'hC001_0000;
    for (int i = 0; i < 16; i++) begin
      total_cnt++;
      if (cap_w[i] !== exp_w[i]) $display("FAIL len56_b2_word%0d: got %h expected %h", i, cap_w[i], exp_w[i]);
      else pass_cnt++;
    end
    pulse_done();
    total_cnt++;
    if (msg_done_o !== 1'b1 || cap_fv !== 16'h0000 || cap_vv !== 16'hFFFF)
      $display("FAIL len56_b2_flags: msg_done=%b first=%h valid=%h expected 1 0000 FFFF",
               msg_done_o, cap_fv, cap_vv);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_len64();
    send_msg(64);
    capture_block();
    for (int i = 0; i < 16; i++) begin
      total_cnt++;
      if (cap_w[i] !== mkw(4 * i)) $display("FAIL len64_b1_word%0d: got %h expected %h", i, cap_w[i], mkw(4 * i));
      else pass_cnt++;
    end
    pulse_done();
    capture_block();
    for (int i = 0; i < 16; i++) exp_w[i] = 32'h0;
    exp_w[0] = 32'h0000_0080; exp_w[15] = 32'h0002_0000;
    for (int i = 0; i < 16; i++) begin
      total_cnt++;
      if (cap_w[i] !== exp_w[i]) $display("FAIL len64_b2_word%0d: got %h expected %h", i, cap_w[i], exp_w[i]);
      else pass_cnt++;
    end
    total_cnt++;
    if (cap_fv !== 16'h0000) $display("FAIL len64_b2_first: got %h expected 0000", cap_fv);
    else pass_cnt++;
    pulse_done();
    total_cnt++;
    if (msg_done_o !== 1'b1) $display("FAIL len64_done: msg_done=%b expected 1", msg_done_o);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    // 66-byte message sent with s_valid held high; the 17th word stalls across WAIT.
    fork
      send_msg(66);
      begin
        capture_block();
        for (int i = 0; i < 16; i++) begin
          total_cnt++;
          if (cap_w[i] !== mkw(4 * i)) $display("FAIL b2b_b1_word%0d: got %h expected %h", i, cap_w[i], mkw(4 * i));
          else pass_cnt++;
        end
        total_cnt++;
        if (cap_vv !== 16'hFFFF || cap_after !== 1'b0 || cap_fv !== 16'hFFFF)
          $display("FAIL b2b_b1_beats: valid=%h after=%b first=%h expected FFFF 0 FFFF", cap_vv, cap_after, cap_fv);
        else pass_cnt++;
        repeat (3) begin
          total_cnt++;
          if (s_ready !== 1'b0) $display("FAIL b2b_backpressure: s_ready=%b expected 0", s_ready);
          else pass_cnt++;
          tick();
        end
        pulse_done();
        total_cnt++;
        if (msg_done_o !== 1'b0) $display("FAIL b2b_mid_done: msg_done=%b expected 0", msg_done_o);
        else pass_cnt++;
        capture_block();
        for (int i = 0; i < 16; i++) exp_w[i] = 32'h0;
        exp_w[0] = 32'h0080_4140; exp_w[15] = 32'h1002_0000;
        for (int i = 0; i < 16; i++) begin
          total_cnt++;
          if (cap_w[i] !== exp_w[i]) $display("FAIL b2b_b2_word%0d: got %h expected %h", i, cap_w[i], exp_w[i]);
          else pass_cnt++;
        end
        pulse_done();
        total_cnt++;
        if (msg_done_o !== 1'b1 || cap_fv !== 16'h0000)
          $display("FAIL b2b_done: msg_done=%b first=%h expected 1 0000", msg_done_o, cap_fv);
        else pass_cnt++;
      end
    join
    tick();
  endtask

  task automatic test_core_busy();
    logic seen;
    seen = 1'b0;
    core_busy_i = 1'b1;
    send_word(32'h0063_6261, 3'd3, 1'b1);
    repeat (10) begin
      seen = seen | blk_valid_o;
      tick();
    end
    total_cnt++;
    if (seen !== 1'b0) $display("FAIL busy_hold: blk_valid_o rose while core busy, got %b expected 0", seen);
    else pass_cnt++;
    core_busy_i = 1'b0;
    capture_block();
    total_cnt++;
    if (cap_w[0] !== 32'h8063_6261 || cap_w[15] !== 32'h1800_0000 || cap_vv !== 16'hFFFF)
      $display("FAIL busy_release: w0=%h w15=%h valid=%h expected 80636261 18000000 FFFF",
               cap_w[0], cap_w[15], cap_vv);
    else pass_cnt++;
    pulse_done();
    tick();
  endtask

  task automatic test_reset_mid_send();
    int n;
    n = 0;
    send_word(32'h0063_6261, 3'd3, 1'b1);
    while (blk_valid_o !== 1'b1 && n < 80) begin tick(); n++; end
    repeat (7) tick();
    total_cnt++;
    if (blk_valid_o !== 1'b1) $display("FAIL rst_send_beat7: blk_valid_o=%b expected 1", blk_valid_o);
    else pass_cnt++;
    rst = 1'b1;
    tick();
    total_cnt++;
    if (blk_valid_o !== 1'b0 || s_ready !== 1'b0)
      $display("FAIL rst_send_drop: blk_valid_o=%b s_ready=%b expected 0 0", blk_valid_o, s_ready);
    else pass_cnt++;
    tick();
    rst = 1'b0;
    tick();
    send_word(32'h0063_6261, 3'd3, 1'b1);
    capture_block();
    for (int i = 0; i < 16; i++) exp_w[i] = 32'h0;
    exp_w[0] = 32'h8063_6261; exp_w[15] = 32'h1800_0000;
    for (int i = 0; i < 16; i++) begin
      total_cnt++;
      if (cap_w[i] !== exp_w[i]) $display("FAIL rst_abc_word%0d: got %h expected %h", i, cap_w[i], exp_w[i]);
      else pass_cnt++;
    end
    pulse_done();
    total_cnt++;
    if (msg_done_o !== 1'b1 || cap_fv !== 16'hFFFF)
      $display("FAIL rst_abc_done: msg_done=%b first=%h expected 1 FFFF", msg_done_o, cap_fv);
    else pass_cnt++;
    tick();
  endtask

  initial begin
    test_reset();
    test_abc();
    test_empty();
    test_len55();
    test_len56();
    test_len64();
    test_back_to_back();
    test_core_busy();
    test_reset_mid_send();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
